data_mem_responder: RTL and testbench

- Memory-side responder for the core's load/store port.
- Serves word `lw`/`sw` requests from the datapath over a req/ack handshake.
- Holds an internal byte-addressed array and transfers one byte per cycle, little-endian (byte at addr → bits [7:0]).
- Replaces the zero-latency data memory with a multi-cycle, handshaked target, so the core's initiator side can be built and verified against it.

---
 rtl/data_mem_responder_if.sv | 22 ++
 rtl/data_mem_responder.sv | 142 ++++++++++++++
 tb/tb_data_mem_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store port between the core's initiator side and the data memory responder.
// The requester holds req until ack; ack/err/rdata/busy come back from the responder.
interface data_mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        busy;

    modport master (
        output req, we, addr, wdata,
        input  ack, err, rdata, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, err, rdata, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word lw/sw responder over a byte array, one byte per cycle, little-endian; ack after 5+WAIT_CYCLES cycles (errors after 1).
// Requester backpressure is req held high; one idle cycle always separates completion from the next accept.
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic CLK,
    input  logic RESET,
    data_mem_responder_if.slave bus
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_XFER, S_DONE, S_ERR} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         shadow_q, shadow_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [1:0]          idx_q, idx_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                hold_q, hold_d;

    logic [7:0]          mem [2**ADDR_W];
    logic [ADDR_W-1:0]   byte_addr;
    logic [7:0]          rd_byte;
    logic [7:0]          wr_byte;
    logic                mem_we;
    logic                bad_addr;

    assign byte_addr = addr_q + ADDR_W'(idx_q);
    assign rd_byte   = mem[byte_addr];
    assign wr_byte   = wdata_q[{idx_q, 3'b000} +: 8];
    assign mem_we    = (state_q == S_XFER) && we_q;
    assign bad_addr  = (bus.addr[1:0] != 2'b00) || ((bus.addr >> ADDR_W) != 32'd0);

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        shadow_d = shadow_q;
        rdata_d  = rdata_q;
        wcnt_d   = wcnt_q;
        idx_d    = idx_q;
        hold_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // hold_q masks the first IDLE edge after a completion
                if (bus.req && !hold_q) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr[ADDR_W-1:0];
                    wdata_d = bus.wdata;
                    idx_d   = 2'd0;
                    wcnt_d  = 4'd0;
                    if (bad_addr) begin
                        state_d = S_ERR;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_XFER;
                    end
                end
            end
            S_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    state_d = S_XFER;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            S_XFER: begin
                if (!we_q) begin
                    shadow_d[{idx_q, 3'b000} +: 8] = rd_byte;
                end
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        rdata_d = shadow_d;
                    end
                end
            end
            S_DONE, S_ERR: begin
                state_d = S_IDLE;
                hold_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ack_d = (state_d == S_DONE) || (state_d == S_ERR);
        err_d = (state_d == S_ERR);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            shadow_q <= 32'h0;
            rdata_q  <= 32'h0;
            wcnt_q   <= 4'd0;
            idx_q    <= 2'd0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            wcnt_q   <= wcnt_d;
            idx_q    <= idx_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            hold_q   <= hold_d;
        end
    end

    // Array contents survive reset; a store interrupted mid-word keeps its finished bytes.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[byte_addr] <= wr_byte;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Drives a WAIT_CYCLES=0 and a WAIT_CYCLES=2 responder with shared stimulus and
// checks them against a byte-array reference model.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        req0, req2, we;
    logic [31:0] addr, wdata;
    logic        ack0, err0, busy0, ack2, err2, busy2;
    logic [31:0] rdata0, rdata2;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    data_mem_responder_if bus0();
    data_mem_responder_if bus2();

    assign bus0.req   = req0;
    assign bus0.we    = we;
    assign bus0.addr  = addr;
    assign bus0.wdata = wdata;
    assign bus2.req   = req2;
    assign bus2.we    = we;
    assign bus2.addr  = addr;
    assign bus2.wdata = wdata;
    assign ack0 = bus0.ack;  assign err0 = bus0.err;  assign busy0 = bus0.busy;  assign rdata0 = bus0.rdata;
    assign ack2 = bus2.ack;  assign err2 = bus2.err;  assign busy2 = bus2.busy;  assign rdata2 = bus2.rdata;

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (.CLK(clk), .RESET(rst_n), .bus(bus0));
    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (.CLK(clk), .RESET(rst_n), .bus(bus2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        tbl[14];
    logic [7:0]  mm[1024];
    logic [31:0] prev_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One transaction on dut0 (and dut2 when en2); checks latency, busy length, err, rdata.
    task automatic txn(input string nm, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic e_err, input logic [31:0] e_rd0, input logic [31:0] e_rd2, input bit en2);
        int c0, lat0, lat2, b0, b2;
        bit got0, got2;
        logic er0, er2;
        logic [31:0] r0, r2;
        repeat (2) @(negedge clk);
        we = w; addr = a; wdata = d; req0 = 1'b1; req2 = en2;
        c0 = cyc; got0 = 1'b0; got2 = !en2; b0 = 0; b2 = 0;
        lat0 = -1; lat2 = -1; er0 = 1'bx; er2 = 1'bx; r0 = 'x; r2 = 'x;
        @(posedge clk);
        #1;
        we = 1'($urandom); addr = $urandom; wdata = $urandom;
        for (int i = 0; i < 40 && !(got0 && got2); i++) begin
            @(negedge clk);
            if (!got0) begin
                if (busy0) b0++;
                if (ack0) begin got0 = 1'b1; lat0 = cyc - c0; er0 = err0; r0 = rdata0; req0 = 1'b0; end
            end
            if (!got2) begin
                if (busy2) b2++;
                if (ack2) begin got2 = 1'b1; lat2 = cyc - c0; er2 = err2; r2 = rdata2; req2 = 1'b0; end
            end
        end
        req0 = 1'b0; req2 = 1'b0;
        chk({nm, " w0 ack_seen"}, 32'(got0), 32'd1);
        chk({nm, " w0 latency"}, 32'(lat0), e_err ? 32'd1 : 32'd5);
        chk({nm, " w0 busy_cycles"}, 32'(b0), e_err ? 32'd1 : 32'd5);
        chk({nm, " w0 err"}, 32'(er0), 32'(e_err));
        chk({nm, " w0 rdata"}, r0, e_rd0);
        if (en2) begin
            chk({nm, " w2 ack_seen"}, 32'(got2), 32'd1);
            chk({nm, " w2 latency"}, 32'(lat2), e_err ? 32'd1 : 32'd7);
            chk({nm, " w2 busy_cycles"}, 32'(b2), e_err ? 32'd1 : 32'd7);
            chk({nm, " w2 err"}, 32'(er2), 32'(e_err));
            chk({nm, " w2 rdata"}, r2, e_rd2);
        end
    endtask

    // Model-driven transaction on both instances.
    task automatic model_txn(input string nm, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic e_err;
        e_err = (a % 4 != 0) || (a >= 32'd1024);
        if (!e_err && w) begin
            for (int b = 0; b < 4; b++) mm[a + b] = d[8*b +: 8];
        end else if (!e_err) begin
            prev_rd = {mm[a + 3], mm[a + 2], mm[a + 1], mm[a]};
        end
        txn(nm, w, a, d, e_err, prev_rd, prev_rd, 1'b1);
    endtask

    initial begin
        int t0[2], t2[2], n0, n2, acks_in_rst;
        logic [31:0] rd0[2], rd2[2];
        logic [31:0] a, d;
        int kind;

        tbl[0]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 1'b0, 32'h0000_0000};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h1122_3344};
        tbl[2]  = '{1'b0, 32'h0000_0011, 32'h0000_0000, 1'b1, 32'h1122_3344};
        tbl[3]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 1'b1, 32'h1122_3344};
        tbl[4]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 32'h1122_3344};
        tbl[5]  = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 1'b1, 32'h1122_3344};
        tbl[6]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
        tbl[7]  = '{1'b1, 32'h0000_0014, 32'h5566_7788, 1'b0, 32'hCAFE_F00D};
        tbl[8]  = '{1'b0, 32'h0000_0014, 32'h0000_0000, 1'b0, 32'h5566_7788};
        tbl[9]  = '{1'b1, 32'h0000_03FC, 32'h0102_0304, 1'b0, 32'h5566_7788};
        tbl[10] = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 1'b0, 32'h0102_0304};
        tbl[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'h0102_0304};
        tbl[12] = '{1'b1, 32'h0000_0002, 32'h0000_0000, 1'b1, 32'h0102_0304};
        tbl[13] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};

        rst_n = 1'b0; req0 = 1'b0; req2 = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
        #12;
        chk("reset ack0", 32'(ack0), 32'd0);
        chk("reset err0", 32'(err0), 32'd0);
        chk("reset busy0", 32'(busy0), 32'd0);
        chk("reset rdata0", rdata0, 32'h0);
        chk("reset busy2", 32'(busy2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata,
                tbl[i].exp_err, tbl[i].exp_rd, tbl[i].exp_rd, 1'b1);
        end

        // Back-to-back loads with req held; address moved to 0x14 during dut0's first ack.
        repeat (2) @(negedge clk);
        we = 1'b0; addr = 32'h10; req0 = 1'b1; req2 = 1'b1; n0 = 0; n2 = 0;
        t0 = '{0, 0}; t2 = '{0, 0}; rd0 = '{32'h0, 32'h0}; rd2 = '{32'h0, 32'h0};
        for (int i = 0; i < 60 && (n0 < 2 || n2 < 2); i++) begin
            @(negedge clk);
            if (ack0 && n0 < 2) begin
                t0[n0] = cyc; rd0[n0] = rdata0; n0++;
                if (n0 == 1) addr = 32'h14;
                if (n0 == 2) req0 = 1'b0;
            end
            if (ack2 && n2 < 2) begin
                t2[n2] = cyc; rd2[n2] = rdata2; n2++;
                if (n2 == 2) req2 = 1'b0;
            end
        end
        req0 = 1'b0; req2 = 1'b0;
        chk("b2b w0 ack count", 32'(n0), 32'd2);
        chk("b2b w0 period", 32'(t0[1] - t0[0]), 32'd7);
        chk("b2b w0 first rdata", rd0[0], 32'h1122_3344);
        chk("b2b w0 second rdata", rd0[1], 32'h5566_7788);
        chk("b2b w2 ack count", 32'(n2), 32'd2);
        chk("b2b w2 period", 32'(t2[1] - t2[0]), 32'd9);
        chk("b2b w2 second rdata", rd2[1], 32'h5566_7788);
        prev_rd = 32'h5566_7788;

        for (int w = 0; w < 16; w++) begin
            model_txn($sformatf("init%0d", w), 1'b1, 32'(4 * w), $urandom);
        end
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) a = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
            else if (kind == 1) a = ($urandom_range(1, 4194303) << 10) | 32'(4 * $urandom_range(0, 255));
            else a = 32'(4 * $urandom_range(0, 15));
            d = $urandom;
            model_txn($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), a, d);
        end

        model_txn("st24", 1'b1, 32'h24, 32'hDEAD_BEEF);
        model_txn("ld24", 1'b0, 32'h24, 32'h0);
        model_txn("zero20", 1'b1, 32'h20, 32'h0);

        // Reset lands after the second XFER edge of a store on dut0.
        repeat (2) @(negedge clk);
        we = 1'b1; addr = 32'h20; wdata = 32'hAABB_CCDD; req0 = 1'b1; req2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst busy0", 32'(busy0), 32'd0);
        chk("midrst ack0", 32'(ack0), 32'd0);
        chk("midrst err0", 32'(err0), 32'd0);
        chk("midrst rdata0", rdata0, 32'h0);
        chk("midrst rdata2", rdata2, 32'h0);
        req0 = 1'b0;
        acks_in_rst = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack0) acks_in_rst++;
        end
        chk("midrst no ack", 32'(acks_in_rst), 32'd0);
        rst_n = 1'b1;
        txn("ld20 after rst", 1'b0, 32'h20, 32'h0, 1'b0, 32'h0000_CCDD, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
